// File: rtl/dac_spi_serializer_if.sv
// Sample handshake between the function generator and the DAC serializer.
// The producer drives the sample and valid; the serializer drives ready.
interface dac_spi_serializer_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] in_sample;
  logic [1:0]        in_pd;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_sample, in_pd, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_sample, in_pd, in_valid,
    output in_ready
  );
endinterface

// File: rtl/dac_spi_serializer.sv
// 12-bit sample to 16-bit SPI DAC frame serializer, MSB first.
// Optional load strobe dac_ldac_n when DAC_LDAC_EN is defined.
module dac_spi_serializer #(
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  dac_spi_serializer_if.slave src,
  output logic dac_cs_n,
  output logic dac_sclk,
  output logic dac_sdata,
  output logic frame_done,
`ifdef DAC_LDAC_EN
  output logic dac_ldac_n,
`endif
  output logic busy
);
  localparam int FW    = DATA_W + 4;
  localparam int BIT_W = $clog2(FW);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef DAC_LDAC_EN
  localparam int LDAC_LEN = 2 * CLK_DIV;
  localparam int GAP_LEN  = (GAP_CYCLES > LDAC_LEN) ?
                            GAP_CYCLES : LDAC_LEN + 1;
`else
  localparam int GAP_LEN  = GAP_CYCLES;
`endif
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t state, state_n;

  logic [FW-1:0]    frame;
  logic [FW-1:0]    shreg, shreg_n;
  logic [BIT_W-1:0] bit_idx, bit_n;
  logic [DIV_W-1:0] div, div_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic             cs_n_n, sclk_n, sdata_n;
  logic             done_n, busy_n;

  assign frame = {2'b00, src.in_pd, src.in_sample};
  assign src.in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_idx;
    div_n   = div;
    gap_n   = gap_cnt;
    cs_n_n  = dac_cs_n;
    sclk_n  = dac_sclk;
    sdata_n = dac_sdata;
    done_n  = 1'b0;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (src.in_valid) begin
          state_n = SHIFT;
          shreg_n = {frame[FW-2:0], 1'b0};
          sdata_n = frame[FW-1];
          cs_n_n  = 1'b0;
          sclk_n  = 1'b1;
          div_n   = '0;
          bit_n   = BIT_W'(FW - 1);
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (dac_sclk) begin
            sclk_n = 1'b0;
          end else if (bit_idx == '0) begin
            state_n = GAP;
            cs_n_n  = 1'b1;
            sclk_n  = 1'b1;
            sdata_n = 1'b0;
            done_n  = 1'b1;
            gap_n   = '0;
          end else begin
            bit_n   = bit_idx - 1'b1;
            sclk_n  = 1'b1;
            sdata_n = shreg[FW-1];
            shreg_n = {shreg[FW-2:0], 1'b0};
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_idx    <= '0;
      div        <= '0;
      gap_cnt    <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_sdata  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      shreg      <= shreg_n;
      bit_idx    <= bit_n;
      div        <= div_n;
      gap_cnt    <= gap_n;
      dac_cs_n   <= cs_n_n;
      dac_sclk   <= sclk_n;
      dac_sdata  <= sdata_n;
      frame_done <= done_n;
      busy       <= busy_n;
    end
  end

`ifdef DAC_LDAC_EN
  // Strobe spans gap counts 1..LDAC_LEN: starts the cycle after frame_done.
  logic ldac_n_n;

  assign ldac_n_n = !((state_n == GAP) &&
                      (gap_n >= GAP_W'(1)) &&
                      (gap_n <= GAP_W'(LDAC_LEN)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_ldac_n <= 1'b1;
    else        dac_ldac_n <= ldac_n_n;
  end
`endif
endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer with a frame scoreboard.
// Captures bits on falling SCLK edges while chip select is low.
module tb_dac_spi_serializer;
  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 2;
`ifdef DAC_LDAC_EN
  localparam int GAP_LEN = (GAP_CYCLES > 2 * CLK_DIV) ?
                           GAP_CYCLES : 2 * CLK_DIV + 1;
`else
  localparam int GAP_LEN = GAP_CYCLES;
`endif
  localparam int PERIOD = 1 + 32 * CLK_DIV + GAP_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dac_cs_n, dac_sclk, dac_sdata, frame_done, busy;
`ifdef DAC_LDAC_EN
  logic dac_ldac_n;
  int   ldac_low = 0;
  int   ldac_start = -1;
  int   fd_cyc = 0;
  int   ldac_ready = 0;
`endif

  dac_spi_serializer_if #(.DATA_W(12)) bus ();

  dac_spi_serializer #(
    .DATA_W(12),
    .CLK_DIV(CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src(bus.slave),
    .dac_cs_n(dac_cs_n),
    .dac_sclk(dac_sclk),
    .dac_sdata(dac_sdata),
    .frame_done(frame_done),
`ifdef DAC_LDAC_EN
    .dac_ldac_n(dac_ldac_n),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int nbits = 0;
  int lowcnt = 0;
  int hi_run = 0;
  int last_hi = 0;
  logic [15:0] sh = '0;
  logic prev_sclk = 1'b1;
  logic prev_cs = 1'b1;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int bits_q[$];
  int low_q[$];
  int acc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits  = 0;
      lowcnt = 0;
      hi_run = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (dac_cs_n) hi_run++;
      else lowcnt++;
      if (!dac_cs_n && prev_cs) begin
        last_hi = hi_run;
        hi_run  = 0;
      end
      if (!dac_cs_n && prev_sclk && !dac_sclk) begin
        sh = {sh[14:0], dac_sdata};
        nbits++;
      end
      if (dac_cs_n && !prev_cs) begin
        got_q.push_back(sh);
        bits_q.push_back(nbits);
        low_q.push_back(lowcnt);
        nbits  = 0;
        lowcnt = 0;
      end
      if (frame_done) fd_cnt++;
`ifdef DAC_LDAC_EN
      if (frame_done) fd_cyc = cyc;
      if (!dac_ldac_n) begin
        if (ldac_low == 0) ldac_start = cyc;
        ldac_low++;
        if (bus.in_ready) ldac_ready++;
      end
`endif
    end
    prev_sclk = dac_sclk;
    prev_cs   = dac_cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, g, e);
    end
  endtask

  task automatic send(input logic [11:0] s, input logic [1:0] p,
                      input bit hold);
    int n = 0;
    @(posedge clk); #1;
    bus.in_sample = s;
    bus.in_pd     = p;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    logic [15:0] g, e;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk(tag, 32'(g), 32'(e));
      chk({tag, "_bits"}, bits_q.pop_front(), 32'd16);
      chk({tag, "_low"}, low_q.pop_front(), 32'(32 * CLK_DIV));
    end
  endtask

  initial begin
    int n;
    int fd0;
    int a0;
    bus.in_sample = '0;
    bus.in_pd     = '0;
    bus.in_valid  = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
    chk("rst_sclk", 32'(dac_sclk), 32'd1);
    chk("rst_sdata", 32'(dac_sdata), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
`ifdef DAC_LDAC_EN
    chk("rst_ldac", 32'(dac_ldac_n), 32'd1);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_cs_n", 32'(dac_cs_n), 32'd1);

    // single frame
    send(12'hA5C, 2'd0, 1'b0);
    exp_q.push_back(16'h0A5C);
    @(negedge clk);
    chk("shift_busy", 32'(busy), 32'd1);
    chk("shift_ready", 32'(bus.in_ready), 32'd0);
    wait_frame("single");
    chk("single_done_cnt", fd_cnt, 32'd1);

    // back-to-back with valid held
    repeat (10) @(negedge clk);
    a0 = acc_q.size();
    send(12'h000, 2'd0, 1'b1);
    exp_q.push_back(16'h0000);
    send(12'hFFF, 2'd0, 1'b0);
    exp_q.push_back(16'h0FFF);
    wait_frame("b2b_first");
    wait_frame("b2b_second");
    chk("b2b_acc_cnt", acc_q.size() - a0, 32'd2);
    if (acc_q.size() - a0 == 2)
      chk("b2b_period", acc_q[a0 + 1] - acc_q[a0], 32'(PERIOD));
    // cs_n high for the gap plus the accepting idle cycle
    chk("b2b_cs_high", last_hi, 32'(GAP_LEN + 1));

    // valid pulses while busy are ignored
    repeat (5) @(negedge clk);
    a0 = acc_q.size();
    send(12'h123, 2'd2, 1'b0);
    exp_q.push_back(16'h2123);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    bus.in_sample = 12'h456;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk("drop_shift_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drop_fd_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("drop_gap_ready", 32'(bus.in_ready), 32'd0);
    chk("drop_gap_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_frame("drop");
    repeat (100) @(negedge clk);
    chk("drop_no_extra", got_q.size(), 32'd0);
    chk("drop_acc_cnt", acc_q.size() - a0, 32'd1);

    // reset in the middle of a frame
    fd0 = fd_cnt;
    send(12'h3C7, 2'd0, 1'b0);
    n = 0;
    while (nbits < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_bits_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_cs_n", 32'(dac_cs_n), 32'd1);
    chk("mid_sclk", 32'(dac_sclk), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_frame", got_q.size(), 32'd0);
    chk("mid_no_done", fd_cnt - fd0, 32'd0);
    send(12'h5A1, 2'd1, 1'b0);
    exp_q.push_back(16'h15A1);
    wait_frame("after_rst");

`ifdef DAC_LDAC_EN
    // load strobe after the frame
    repeat (10) @(negedge clk);
    ldac_low   = 0;
    ldac_start = -1;
    ldac_ready = 0;
    send(12'h800, 2'd0, 1'b0);
    exp_q.push_back(16'h0800);
    wait_frame("ldac");
    repeat (20) @(negedge clk);
    chk("ldac_len", ldac_low, 32'(2 * CLK_DIV));
    chk("ldac_start", ldac_start - fd_cyc, 32'd1);
    chk("ldac_ready_low", ldac_ready, 32'd0);
    chk("ldac_idle", 32'(dac_ldac_n), 32'd1);
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
